// File: rtl/hamming_secded_decoder_pipe_if.sv
// ============================================================================
// hamming_secded_decoder_pipe_if : stream and status bundle for the SECDED decoder
// Rev 1.0
// ============================================================================
`default_nettype none

interface hamming_secded_decoder_pipe_if #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r = r + 1;
        return r;
    endfunction

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [DATA_W-1:0] out_data;
    logic              out_sed;
    logic              out_ded;
    logic [PAR_W:0]    out_err_pos;
    logic              clr_cnt;
    logic [CNT_W-1:0]  sec_cnt;
    logic [CNT_W-1:0]  ded_cnt;
    logic              first_err_vld;
    logic [PAR_W:0]    first_err_syn;

    modport master (
        output in_valid, in_code, out_ready, clr_cnt,
        input  in_ready, out_valid, out_code, out_data, out_sed, out_ded,
               out_err_pos, sec_cnt, ded_cnt, first_err_vld, first_err_syn
    );

    modport slave (
        input  in_valid, in_code, out_ready, clr_cnt,
        output in_ready, out_valid, out_code, out_data, out_sed, out_ded,
               out_err_pos, sec_cnt, ded_cnt, first_err_vld, first_err_syn
    );
endinterface

`default_nettype wire

// File: rtl/hamming_secded_decoder_pipe.sv
// ============================================================================
// hamming_secded_decoder_pipe : 2-stage extended-Hamming SECDED decoder with
// saturating SEC/DED counters; HAMMING_DEC_ERR_LOG_EN adds a first-error log.
// Rev 1.0
// ============================================================================
`default_nettype none

module hamming_secded_decoder_pipe #(
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    hamming_secded_decoder_pipe_if.slave  bus
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r = r + 1;
        return r;
    endfunction

    localparam int               PAR_W    = calc_par_w(DATA_W);
    localparam int               CODE_W   = DATA_W + PAR_W + 1;
    localparam logic [PAR_W:0]   CODE_W_V = (PAR_W + 1)'(CODE_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Codeword position of payload bit idx: the idx-th non-power-of-two position >= 3.
    function automatic int data_pos(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 3; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = p;
                cnt = cnt + 1;
            end
        end
        return res;
    endfunction

    logic              ready_en_q;
    logic              s1_vld_q;
    logic [CODE_W-1:0] s1_code_q;
    logic              s2_vld_q;
    logic [CODE_W-1:0] code_q;
    logic [DATA_W-1:0] data_q;
    logic              sed_q;
    logic              ded_q;
    logic [PAR_W:0]    pos_q;
    logic [CNT_W-1:0]  sec_cnt_q;
    logic [CNT_W-1:0]  ded_cnt_q;

    logic [PAR_W-1:0]  syn_d;
    logic              ov_d;
    logic              sec_d;
    logic              ded_d;
    logic [PAR_W:0]    pos_d;
    logic [CODE_W-1:0] corr_d;
    logic [DATA_W-1:0] data_d;

    logic in_fire;
    logic out_fire;
    logic s2_load;

    assign out_fire     = s2_vld_q & bus.out_ready;
    assign s2_load      = s1_vld_q & (~s2_vld_q | bus.out_ready);
    // ready_en_q keeps in_ready low throughout reset and for the first edge after it.
    assign bus.in_ready = ready_en_q & (~s1_vld_q | s2_load);
    assign in_fire      = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_code_q  <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (in_fire) begin
                s1_vld_q  <= 1'b1;
                s1_code_q <= bus.in_code;
            end else if (s2_load) begin
                s1_vld_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        syn_d = '0;
        for (int p = 1; p < CODE_W; p++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if (((p >> k) & 1) == 1) syn_d[k] = syn_d[k] ^ s1_code_q[p];
            end
        end
    end

    assign ov_d   = ^s1_code_q;
    // A syndrome pointing past the last bit cannot be a single error.
    assign sec_d  = ov_d & ({1'b0, syn_d} < CODE_W_V);
    assign ded_d  = (~ov_d & (syn_d != '0)) | (ov_d & ~sec_d);
    assign pos_d  = sec_d ? {1'b0, syn_d} : '0;
    assign corr_d = s1_code_q ^ (sec_d ? (CODE_W'(1) << syn_d) : '0);

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        assign data_d[i] = corr_d[data_pos(i)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            code_q   <= '0;
            data_q   <= '0;
            sed_q    <= 1'b0;
            ded_q    <= 1'b0;
            pos_q    <= '0;
        end else if (s2_load) begin
            s2_vld_q <= 1'b1;
            code_q   <= corr_d;
            data_q   <= data_d;
            sed_q    <= sec_d;
            ded_q    <= ded_d;
            pos_q    <= pos_d;
        end else if (out_fire) begin
            s2_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (bus.clr_cnt) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (out_fire) begin
            if (sed_q && (sec_cnt_q != CNT_MAX)) sec_cnt_q <= sec_cnt_q + 1'b1;
            if (ded_q && (ded_cnt_q != CNT_MAX)) ded_cnt_q <= ded_cnt_q + 1'b1;
        end
    end

    assign bus.out_valid   = s2_vld_q;
    assign bus.out_code    = code_q;
    assign bus.out_data    = data_q;
    assign bus.out_sed     = sed_q;
    assign bus.out_ded     = ded_q;
    assign bus.out_err_pos = pos_q;
    assign bus.sec_cnt     = sec_cnt_q;
    assign bus.ded_cnt     = ded_cnt_q;

`ifdef HAMMING_DEC_ERR_LOG_EN
    logic           log_vld_q;
    logic [PAR_W:0] log_syn_q;
    logic [PAR_W:0] s2_syn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_syn_q <= '0;
        end else if (s2_load) begin
            s2_syn_q <= {ov_d, syn_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_vld_q <= 1'b0;
            log_syn_q <= '0;
        end else if (bus.clr_cnt) begin
            log_vld_q <= 1'b0;
            log_syn_q <= '0;
        end else if (out_fire && (sed_q || ded_q) && !log_vld_q) begin
            log_vld_q <= 1'b1;
            log_syn_q <= s2_syn_q;
        end
    end

    assign bus.first_err_vld = log_vld_q;
    assign bus.first_err_syn = log_syn_q;
`else
    assign bus.first_err_vld = 1'b0;
    assign bus.first_err_syn = '0;
`endif

endmodule

`default_nettype wire
